// File: rtl/rng_pkg.sv
// rng_pkg: shared FSM state type and LFSR tap table for the symbol generator
package rng_pkg;
  typedef enum logic {IDLE, DRAW} state_t;
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 8 ? 32'hB8 : w == 24 ? 32'hE10000 : w == 32 ? 32'h80200003 : 32'hB400;
  endfunction
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: free-running seedable Fibonacci LFSR with zero-seed substitution
module lfsr_core
  import rng_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed_in,
  output logic [LFSR_W-1:0] o_lfsr
);
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));
  logic [LFSR_W-1:0] r_lfsr;
  // shift every cycle; a load wins, and an all-zero seed would lock up so it becomes SEED
  always_ff @(posedge clk)
    if (reset) r_lfsr <= SEED;
    else if (i_seed_load) r_lfsr <= ~|i_seed_in ? SEED : i_seed_in;
    else r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
  assign o_lfsr = r_lfsr;
endmodule

// File: rtl/rand_symbol_gen.sv
// rand_symbol_gen: uniform symbol source with rejection sampling, round-robin fallback and run limiter
module rand_symbol_gen
  import rng_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter int SYM_W = 2,
  parameter int NUM_SYM = 3,
  parameter int MAX_RUN = 3,
  parameter int REJ_LIMIT = 4,
  parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              busy,
  output logic              rand_valid,
  output logic [SYM_W-1:0]  rand_out
);
  localparam int RJ_W = $clog2(REJ_LIMIT + 1);
  localparam int RN_W = $clog2(MAX_RUN + 1);
  localparam logic [SYM_W:0] NS = (SYM_W + 1)'(NUM_SYM);
  localparam logic [SYM_W-1:0] TOP = SYM_W'(NUM_SYM - 1);
  localparam logic [RJ_W-1:0] RL = RJ_W'(REJ_LIMIT);
  localparam logic [RN_W-1:0] MR = RN_W'(MAX_RUN);
  state_t            r_state, w_next;
  logic [LFSR_W-1:0] w_lfsr;
  logic [SYM_W-1:0]  r_rr, r_last, w_cand, w_base, w_inc, w_pick;
  logic [RJ_W-1:0]   r_rej;
  logic [RN_W-1:0]   r_run;
  logic              r_have, w_oob, w_rej, w_emit;
  lfsr_core #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk(clk), .reset(reset), .i_seed_load(seed_load), .i_seed_in(seed_in), .o_lfsr(w_lfsr)
  );
  assign w_cand = w_lfsr[SYM_W-1:0];
  assign w_oob  = {1'b0, w_cand} >= NS;
  assign w_rej  = w_oob && r_rej < RL;
  assign w_base = w_oob ? r_rr : w_cand;
  assign w_inc  = w_base == TOP ? '0 : w_base + 1'b1;
  assign w_pick = (r_have && w_base == r_last && r_run == MR) ? w_inc : w_base;
  assign w_emit = r_state == DRAW && !w_rej;
  assign busy       = r_state == DRAW;
  assign rand_out   = r_last;
  // next state: idle waits for req, a draw leaves as soon as it is not rejecting
  always_comb begin
    w_next = r_state == IDLE ? (req ? DRAW : IDLE) : (w_rej ? DRAW : IDLE);
  end
  // state register
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // round-robin counter, rejection count, run tracking and output registers
  always_ff @(posedge clk)
    if (reset) begin
      r_rr       <= '0;
      r_rej      <= '0;
      r_run      <= '0;
      r_have     <= 1'b0;
      r_last     <= '0;
      rand_valid <= 1'b0;
    end else begin
      r_rr       <= r_rr == TOP ? '0 : r_rr + 1'b1;
      r_rej      <= r_state == IDLE ? '0 : w_rej ? r_rej + 1'b1 : r_rej;
      rand_valid <= w_emit;
      if (w_emit) begin
        r_last <= w_pick;
        r_have <= 1'b1;
        r_run  <= (r_have && w_pick == r_last) ? (r_run == MR ? MR : r_run + 1'b1) : RN_W'(1);
      end
    end
endmodule

// File: tb/tb_rand_symbol_gen.sv
// tb_rand_symbol_gen: randomized self-checking bench against a transaction-level reference model
module tb_rand_symbol_gen;
  localparam int NS = 3;
  localparam int MAXR = 2;
  localparam int REJ = 1;
  localparam logic [15:0] SEED = 16'hACE1;
  logic        clk = 0, reset = 1, seed_load = 0, req = 0;
  logic [15:0] seed_in = '0;
  logic        busy, rand_valid;
  logic [1:0]  rand_out;
  int n_chk = 0, n_pass = 0;
  logic [15:0] m_lfsr;
  int          m_cyc;
  logic [1:0]  m_last = '0;
  bit          m_have = 0;
  int          m_run = 0;
  int cnt_dut[4], cnt_mod[4];
  rand_symbol_gen #(.LFSR_W(16), .SYM_W(2), .NUM_SYM(NS), .MAX_RUN(MAXR), .REJ_LIMIT(REJ), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(busy), .rand_valid(rand_valid), .rand_out(rand_out)
  );
  always #5 clk = ~clk;
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  // reference LFSR sequence and cycle count since reset; the round-robin value is m_cyc mod NS
  always @(posedge clk)
    if (reset) begin
      m_lfsr <= SEED;
      m_cyc  <= 0;
    end else begin
      m_lfsr <= seed_load ? (seed_in == 0 ? SEED : seed_in) : step(m_lfsr);
      m_cyc  <= m_cyc + 1;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask
  task automatic draw(input string tag, input bit ld, input logic [15:0] sd, input bit mid_ld,
                      input logic [15:0] mid_sd, input bit stray, output int lat, output bit fb);
    int rej;
    bit done;
    logic [1:0] cand, pick;
    req = 1; seed_load = ld; seed_in = sd;
    @(posedge clk); #1;
    req = 0; seed_load = 0;
    rej = 0; done = 0; lat = 1; fb = 0; pick = '0;
    while (!done && lat < 20) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_early_valid"}, rand_valid, 0);
      cand = m_lfsr[1:0];
      if (cand >= NS && rej < REJ) rej++;
      else begin
        fb = cand >= NS;
        pick = fb ? 2'(m_cyc % NS) : cand;
        done = 1;
      end
      if (lat == 1) begin seed_load = mid_ld; seed_in = mid_sd; req = stray; end
      @(posedge clk); #1;
      seed_load = 0; req = 0; lat++;
    end
    chk({tag, "_done"}, done, 1);
    if (m_have && pick == m_last && m_run == MAXR) pick = 2'((pick + 1) % NS);
    m_run  = (m_have && pick == m_last) ? (m_run < MAXR ? m_run + 1 : MAXR) : 1;
    m_last = pick;
    m_have = 1;
    chk({tag, "_valid"}, rand_valid, 1);
    chk({tag, "_out"}, rand_out, pick);
    chk({tag, "_busy_drop"}, busy, 0);
  endtask
  initial begin
    int lat, run, maxrun, gap;
    bit fb, quiet;
    logic [1:0] prev;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", rand_out, 0);
    chk("rst_valid", rand_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr", dut.w_lfsr, SEED);
    reset = 0;
    quiet = 1;
    repeat (5) begin @(posedge clk); #1; if (rand_valid || busy) quiet = 0; end
    chk("no_req_quiet", quiet, 1);
    draw("rej_accept", 1, 16'h0003, 0, 0, 0, lat, fb);
    chk("rej_accept_sym", rand_out, 2);
    chk("rej_accept_lat", lat, 3);
    draw("fallback", 1, 16'h8003, 0, 0, 0, lat, fb);
    chk("fallback_taken", fb, 1);
    chk("fallback_lat", lat, 3);
    draw("stray", 0, 0, 0, 0, 1, lat, fb);
    quiet = 1;
    repeat (3) begin @(posedge clk); #1; if (rand_valid || busy) quiet = 0; end
    chk("stray_ignored", quiet, 1);
    draw("mid_seed", 1, 16'h0001, 1, 16'h0003, 0, lat, fb);
    draw("mid_seed_rnd", 0, 0, 1, 16'($urandom), 0, lat, fb);
    req = 1;
    @(posedge clk); #1;
    req = 0; reset = 1;
    @(posedge clk); #1;
    chk("mid_rst_valid", rand_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out", rand_out, 0);
    reset = 0; m_have = 0; m_run = 0; m_last = '0;
    quiet = 1;
    repeat (3) begin @(posedge clk); #1; if (rand_valid || busy) quiet = 0; end
    chk("mid_rst_quiet", quiet, 1);
    draw("after_rst", 0, 0, 0, 0, 0, lat, fb);
    seed_load = 1; seed_in = '0;
    @(posedge clk); #1;
    seed_load = 0;
    chk("zero_seed", dut.w_lfsr, SEED);
    prev = rand_out; run = 0; maxrun = 0;
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] s;
      s = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      draw("rnd", $urandom_range(0, 31) == 0, s, $urandom_range(0, 31) == 0,
           16'($urandom), $urandom_range(0, 15) == 0, lat, fb);
      cnt_dut[rand_out]++;
      cnt_mod[m_last]++;
      run = (i > 0 && rand_out == prev) ? run + 1 : 1;
      maxrun = run > maxrun ? run : maxrun;
      prev = rand_out;
      gap = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    chk("max_run", maxrun <= MAXR, 1);
    chk("illegal_sym", cnt_dut[3], 0);
    for (int k = 0; k < NS; k++) begin
      int d;
      d = cnt_dut[k] - cnt_mod[k];
      d = d < 0 ? -d : d;
      chk($sformatf("dist_%0d", k), d * 20 <= cnt_mod[k], 1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rand_symbol_gen.md
# rand_symbol_gen

Parametrised pseudo-random symbol source for the game logic. It draws uniformly from 0..NUM_SYM-1 using a free-running seedable LFSR, rejection sampling and a bounded round-robin fallback. A run limiter prevents more than MAX_RUN identical consecutive outputs. Consumers request one symbol at a time through a req/valid handshake. It replaces the fixed 2-bit, 3-bit-LFSR generator.

## Interface
Parameters:
- LFSR_W, 16: LFSR width. Supported values are 8, 16, 24 and 32.
- SYM_W, 2: output symbol width. Must satisfy SYM_W ≤ LFSR_W.
- NUM_SYM, 3: number of legal symbols, 2..2^SYM_W.
- MAX_RUN, 3: maximum identical consecutive outputs, ≥1.
- REJ_LIMIT, 4: consecutive rejections before fallback, ≥1.
- SEED, 16'hACE1: reset seed. It also replaces any all-zero seed. Must be nonzero.

Ports:
- clk, in, 1: the single clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high.
- seed_load, in, 1: load seed_in into the LFSR.
- seed_in, in, LFSR_W: seed value.
- req, in, 1: request one symbol. Sampled only while idle.
- busy, out, 1: a draw is in progress.
- rand_valid, out, 1: one-cycle pulse when rand_out is new.
- rand_out, out, SYM_W: last emitted symbol. Held until the next emission.

## Operation
- **LFSR:** Fibonacci, shift-left.
  - next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
  - TAPS per width: 8'hB8, 16'hB400, 24'hE10000, 32'h80200003.
  - Advances every cycle unless reset or seed_load is asserted.
  - seed_load writes seed_in, or SEED if seed_in == 0.
- **Candidate:** cand = lfsr[SYM_W-1:0], taken from the current register value.
- **Round-robin counter rr:** free-running, counts 0..NUM_SYM-1 and wraps. Cleared by reset.
- **FSM states:** IDLE and DRAW.
  - IDLE: if req, go to DRAW and clear rej_cnt. busy = (state == DRAW).
  - DRAW, each cycle:
    - If cand ≥ NUM_SYM and rej_cnt < REJ_LIMIT: reject. rej_cnt++, stay in DRAW.
    - Otherwise pick = (cand ≥ NUM_SYM) ? rr : cand.
    - Run limit: if have_last && pick == last && run_cnt == MAX_RUN, then pick = (pick+1) mod NUM_SYM.
    - Emit: rand_out ← pick, rand_valid ← 1, go to IDLE.
- **Run tracking:**
  - On emit, run_cnt ← (have_last && pick == last) ? run_cnt+1 : 1.
  - last ← pick, have_last ← 1.
  - run_cnt saturates at MAX_RUN and never exceeds it.
- **Ignored inputs:** req while busy is ignored, not queued.
- **seed_load in the same cycle as DRAW:**
  - The draw evaluates the pre-load lfsr.
  - The load takes effect at the edge.
  - The FSM is unaffected.
- **seed_load with req while IDLE:** both take effect. The first DRAW cycle uses the new seed.
- **Reset (including mid-draw):**
  - State ← IDLE, lfsr ← SEED, rr, rej_cnt and run_cnt ← 0, have_last ← 0.
  - rand_out ← 0, rand_valid ← 0, busy ← 0.
  - Any draw in progress is abandoned; no output is produced for it.

## Timing
- req sampled at edge t → busy high from t+1.
- The earliest accept is evaluated in cycle t+1. rand_valid and the new rand_out appear after edge t+2, for exactly one cycle of valid.
- Worst-case latency from req edge to rand_valid is REJ_LIMIT+2 cycles. The fallback always emits.
- busy drops in the same cycle rand_valid rises. A new req may be sampled in that same cycle.
- Throughput: at most one symbol per 2 cycles.
- If NUM_SYM == 2^SYM_W, rejection never occurs and latency is fixed at 2.

## Structure
- Package rng_pkg holds:
  - the state enum (IDLE, DRAW);
  - the function lfsr_taps(width) returning the tap constants above.
- Sub-module lfsr_core holds the LFSR register, seed_load and zero-seed substitution. It is parametrised by LFSR_W and SEED.
- The top level holds the FSM, rr, rejection and run-limit logic.

## Test plan
1. **Reset values.** Assert reset for 2 cycles. Required: rand_out=0, rand_valid=0, busy=0, internal lfsr=16'hACE1. No valid appears without req.
2. **Rejection then accept.** NUM_SYM=3. seed_load=1, seed_in=16'h0003 and req=1 at edge A.
   - Cycle A+1: cand=3, rejected; lfsr → 16'h0006.
   - Cycle A+2: cand=2, accepted.
   - Required: rand_valid high after edge A+3 with rand_out=2, and busy high for exactly 2 cycles.
3. **Zero seed.** seed_load with seed_in=0. Required: lfsr=16'hACE1 the next cycle, and the generator never locks up over 1000 draws.
4. **Fallback.** REJ_LIMIT=1, with the seed chosen so that two consecutive candidates equal 3. Required: the emitted symbol equals rr at the fallback cycle, and latency is exactly 3.
5. **Run limit and distribution.** MAX_RUN=1, NUM_SYM=4, 10000 back-to-back reqs, checked against a golden model. Required:
   - no two consecutive equal outputs;
   - every output < NUM_SYM;
   - each symbol count within ±5% of its expected count under the limiter.
6. **Mid-operation events.**
   - req asserted while busy: no extra valid.
   - reset in the DRAW cycle: no valid, and state returns to IDLE.
   - seed_load during DRAW: the emitted value comes from the pre-load lfsr.
